// File: rtl/stack_pkg.sv
// Shared encodings for the stack cache: command opcodes and controller states.
package stack_pkg;

   typedef enum logic [1:0] {
      OP_NOP     = 2'b00,
      OP_POP     = 2'b01,
      OP_PUSH    = 2'b10,
      OP_REPLACE = 2'b11
   } op_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_e;

endpackage

// File: rtl/stack_ram.sv
// Single-port synchronous spill RAM: one access per cycle, 1-cycle read latency, no reset.
module stack_ram #(
   parameter int AW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rden,
   input  logic          wren,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wren) mem[addr] <= wdata;
      if (rden) rdata <= mem[addr];
   end

endmodule

// File: rtl/stack_cache.sv
// Hardware stack: top NREG entries held in registers, older entries spilled to a RAM.
//   state   | meaning
//   IDLE    | accepting commands; starts a refill when the cache has room and RAM holds entries
//   FILL    | RAM read in flight; read data lands in R[c] this cycle
module stack_cache
   import stack_pkg::*;
#(
   parameter int AW   = 8,
   parameter int DW   = 16,
   parameter int NREG = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          cmd_valid,
   input  logic [1:0]    cmd_op,
   output logic          cmd_ready,
   input  logic [DW-1:0] in,
   output logic [DW-1:0] s0,
   output logic [DW-1:0] s1,
   output logic [AW+1:0] depth,
   output logic          ovf,
   output logic          udf,
   input  logic          clr_err
);

   localparam int CW      = $clog2(NREG + 1);
   localparam int DEPTH_W = AW + 2;
   localparam int MAXD    = 2**AW + NREG;

   state_e              state;
   logic [CW-1:0]       c;
   logic [AW:0]         m;
   logic [AW:0]         m_dec;
   logic [DEPTH_W-1:0]  depth_q;
   logic [DW-1:0]       r [NREG];

   op_e                 op;
   logic                accept, is_empty, is_full, cache_full;
   logic                push_ok, pop_ok, rep_ok, ovf_set, udf_set, spill, refill;
   logic                ram_rden, ram_wren;
   logic [AW-1:0]       ram_addr;
   logic [DW-1:0]       ram_wdata, ram_rdata;

   assign op    = op_e'(cmd_op);
   assign m_dec = m - 1'b1;

   always_comb begin
      cmd_ready  = (state == ST_IDLE) && !((c == '0) && (m != '0));
      accept     = cmd_valid && cmd_ready;
      is_empty   = (depth_q == '0);
      is_full    = (depth_q == DEPTH_W'(MAXD));
      cache_full = (c == CW'(NREG));
      push_ok    = accept && !is_full && ((op == OP_PUSH) || ((op == OP_REPLACE) && is_empty));
      pop_ok     = accept && (op == OP_POP) && !is_empty;
      rep_ok     = accept && (op == OP_REPLACE) && !is_empty;
      ovf_set    = accept && (op == OP_PUSH) && is_full;
      udf_set    = accept && (op == OP_POP) && is_empty;
      spill      = push_ok && cache_full;
      // Refill only in a cycle the command path leaves untouched, so RAM never sees read and write together.
      refill     = (state == ST_IDLE) && !(accept && (op != OP_NOP)) && !cache_full && (m != '0);
      ram_wren   = spill;
      ram_rden   = refill;
      ram_addr   = spill ? m[AW-1:0] : m_dec[AW-1:0];
      ram_wdata  = r[NREG-1];
   end

   stack_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk   (clk),
      .rden  (ram_rden),
      .wren  (ram_wren),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         c       <= '0;
         m       <= '0;
         depth_q <= '0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
         for (int i = 0; i < NREG; i++) r[i] <= '0;
      end else begin
         if (state == ST_FILL) begin
            r[c]  <= ram_rdata;
            c     <= c + 1'b1;
            state <= ST_IDLE;
         end else if (push_ok) begin
            for (int i = NREG-1; i > 0; i--) r[i] <= r[i-1];
            r[0]    <= in;
            depth_q <= depth_q + 1'b1;
            if (cache_full) m <= m + 1'b1;
            else            c <= c + 1'b1;
         end else if (pop_ok) begin
            for (int i = 0; i < NREG-1; i++) r[i] <= r[i+1];
            r[NREG-1] <= '0;
            c         <= c - 1'b1;
            depth_q   <= depth_q - 1'b1;
         end else if (rep_ok) begin
            r[0] <= in;
         end else if (refill) begin
            m     <= m_dec;
            state <= ST_FILL;
         end

         if (clr_err) begin
            ovf <= 1'b0;
            udf <= 1'b0;
         end else begin
            if (ovf_set) ovf <= 1'b1;
            if (udf_set) udf <= 1'b1;
         end
      end
   end

   assign s0    = r[0];
   assign s1    = r[1];
   assign depth = depth_q;

endmodule
